// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Contents: state_t FSM encoding, WIDTH_DEFAULT operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder built from two half-adder stages and an OR.
// Ports: a, b, ci (inputs); s (sum), co (carry out).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder: operand bits
  assign hs1 = a ^ b;
  assign hc1 = a & b;

  // Second half adder: partial sum with incoming carry
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;

  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with valid/ready
// handshakes on both sides.
// Ports: clk, rst_n (async active-low), ena (global enable, freezes state),
//        in_valid/in_ready/a/b (operand handshake), out_valid/out_ready/sum/
//        carry_out (result handshake).
// Optional: define SERIAL_ADDER_SUB_EN to add input 'sub' selecting a-b
//           (carry_out=1 then means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             carry_out
);

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               carry_q,     carry_d;
  logic               in_ready_d;
  logic               out_valid_d;
  logic [WIDTH-1:0]   sum_d;
  logic               carry_out_d;

  logic               sub_op;
  logic [WIDTH-1:0]   b_load;
  logic               fa_s;
  logic               fa_co;

  // Subtract mode: two's complement via inverted b and carry preset to 1
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif
  assign b_load = sub_op ? ~b : b;

  // Single full-adder stage shared by every BUSY cycle
  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      sum       <= sum_d;
      carry_out <= carry_out_d;
    end
  end

  // Next-state and next-output logic; ena low holds everything
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    sum_d       = sum;
    carry_out_d = carry_out;

    if (ena) begin
      case (state_q)
        IDLE: begin
          in_ready_d = 1'b1;
          // in_ready is still low on the first edge after reset, so no accept there
          if (in_valid && in_ready) begin
            a_d        = a;
            b_d        = b_load;
            carry_d    = sub_op;
            cnt_d      = '0;
            in_ready_d = 1'b0;
            state_d    = BUSY;
          end
        end

        BUSY: begin
          in_ready_d = 1'b0;
          a_d        = {1'b0, a_q[WIDTH-1:1]};
          b_d        = {1'b0, b_q[WIDTH-1:1]};
          // New bit enters at the MSB so the first bit lands at the LSB after WIDTH steps
          sum_d      = {fa_s, sum[WIDTH-1:1]};
          carry_d    = fa_co;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            carry_out_d = fa_co;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end

        DONE: begin
          out_valid_d = 1'b1;
          if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end
        end

        default: begin
          state_d     = IDLE;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule
